// File: rtl/cnn_frame_loader.sv
// cnn_frame_loader: front end of the CNN core.
// Collects one NPIX-pixel frame from a valid/ready stream into a flat image
// register, pulses the core's reset and start, waits for its done pulse, and
// hands the scalar result to a valid/ready consumer. Frame-length violations
// and a hung core are reported with single-cycle error pulses.
module cnn_frame_loader #(
  parameter int NPIX    = 64,
  parameter int DW      = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_last,
  output logic [NPIX*DW-1:0]   img_flat,
  output logic                 cnn_rst,
  output logic                 cnn_enable,
  input  logic                 cnn_done,
  input  logic [DW-1:0]        cnn_value,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DW-1:0]        res_data,
  output logic                 err_len,
  output logic                 err_timeout
);

  localparam int AW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(NPIX - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FILL,
    S_DRAIN,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [WW-1:0]   wd_reg, wd_next;
  logic [DW-1:0]   res_data_reg, res_data_next;
  logic            res_valid_reg, res_valid_next;
  logic            cnn_rst_reg, cnn_rst_next;
  logic            cnn_enable_reg, cnn_enable_next;
  logic            err_len_reg, err_len_next;
  logic            err_timeout_reg, err_timeout_next;

  logic            beat_fire;
  logic            fill_write;
  logic            ptr_at_last;
  logic            wd_expired;

  // The stream is open only while collecting or draining a frame, and never in reset.
  assign in_ready    = ~rst & ((state_reg == S_FILL) | (state_reg == S_DRAIN));
  assign beat_fire   = in_valid & in_ready;
  assign fill_write  = beat_fire & (state_reg == S_FILL);
  assign ptr_at_last = (wr_ptr_reg == LAST_PTR);
  assign wd_expired  = (wd_reg == WD_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: frame collection, core launch, wait and result handoff.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FILL: begin
        if (beat_fire) begin
          if (in_last && ptr_at_last) begin
            state_next = S_CLEAR;
          end else if (!in_last && ptr_at_last) begin
            // Frame is longer than the image: discard the rest of it.
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (beat_fire && in_last) begin
          state_next = S_FILL;
        end
      end
      S_CLEAR:  state_next = S_LAUNCH;
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT: begin
        if (cnn_done) begin
          state_next = S_RESULT;
        end else if (wd_expired) begin
          // Abandon the frame; the next frame's core reset recovers the core.
          state_next = S_FILL;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          state_next = S_FILL;
        end
      end
      default: state_next = S_FILL;
    endcase
  end

  // Output and datapath next values; every output except in_ready is registered from these.
  always_comb begin
    wr_ptr_next      = wr_ptr_reg;
    wd_next          = wd_reg;
    res_data_next    = res_data_reg;
    err_len_next     = 1'b0;
    err_timeout_next = 1'b0;
    case (state_reg)
      S_FILL: begin
        if (beat_fire) begin
          if (in_last) begin
            // A complete frame or a short one: either way the next frame starts at word 0.
            wr_ptr_next  = '0;
            err_len_next = ~ptr_at_last;
          end else begin
            wr_ptr_next  = ptr_at_last ? '0 : wr_ptr_reg + 1'b1;
            err_len_next = ptr_at_last;
          end
        end
      end
      S_DRAIN: begin
        if (beat_fire && in_last) begin
          wr_ptr_next = '0;
        end
      end
      S_LAUNCH: begin
        wd_next = '0;
      end
      S_WAIT: begin
        if (cnn_done) begin
          res_data_next = cnn_value;
        end else if (wd_expired) begin
          wd_next          = '0;
          err_timeout_next = 1'b1;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end
      default: ;
    endcase
    cnn_rst_next    = (state_next == S_CLEAR);
    cnn_enable_next = (state_next == S_LAUNCH);
    res_valid_next  = (state_next == S_RESULT);
  end

  // Control, watchdog and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      wd_reg          <= '0;
      res_data_reg    <= '0;
      res_valid_reg   <= 1'b0;
      cnn_rst_reg     <= 1'b0;
      cnn_enable_reg  <= 1'b0;
      err_len_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      wd_reg          <= wd_next;
      res_data_reg    <= res_data_next;
      res_valid_reg   <= res_valid_next;
      cnn_rst_reg     <= cnn_rst_next;
      cnn_enable_reg  <= cnn_enable_next;
      err_len_reg     <= err_len_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  // Image buffer: one register per pixel word, written only by accepted FILL beats.
  // The whole buffer feeds the core in parallel, so it cannot live in a RAM.
  generate
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_word
      logic [DW-1:0] word_reg;

      // Capture the beat addressed to this word.
      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (fill_write && (wr_ptr_reg == AW'(gi))) begin
          word_reg <= in_data;
        end
      end

      assign img_flat[gi*DW +: DW] = word_reg;
    end
  endgenerate

  assign cnn_rst     = cnn_rst_reg;
  assign cnn_enable  = cnn_enable_reg;
  assign res_valid   = res_valid_reg;
  assign res_data    = res_data_reg;
  assign err_len     = err_len_reg;
  assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Testbench for cnn_frame_loader: table-driven frames, hand-written timing
// sequences and randomized frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_cnn_frame_loader;

  localparam int NPIX = 64;
  localparam int DW   = 32;
  localparam int TO_T = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                in_valid, in_last, in_ready;
  logic [DW-1:0]       in_data;
  logic [NPIX*DW-1:0]  img_flat;
  logic                cnn_rst, cnn_enable, cnn_done;
  logic [DW-1:0]       cnn_value;
  logic                res_valid, res_ready;
  logic [DW-1:0]       res_data;
  logic                err_len, err_timeout;

  logic                t_in_valid, t_in_last, t_in_ready;
  logic [DW-1:0]       t_in_data;
  logic [NPIX*DW-1:0]  t_img_flat;
  logic                t_cnn_rst, t_cnn_enable;
  logic                t_cnn_done = 1'b0;
  logic [DW-1:0]       t_cnn_value = '0;
  logic                t_res_valid;
  logic                t_res_ready = 1'b1;
  logic [DW-1:0]       t_res_data;
  logic                t_err_len, t_err_timeout;

  cnn_frame_loader #(.NPIX(NPIX), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .img_flat(img_flat),
    .cnn_rst(cnn_rst), .cnn_enable(cnn_enable), .cnn_done(cnn_done), .cnn_value(cnn_value),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err_len(err_len), .err_timeout(err_timeout)
  );

  // Second instance with a short watchdog and a core that never finishes.
  cnn_frame_loader #(.NPIX(NPIX), .DW(DW), .TIMEOUT(TO_T)) dut_to (
    .clk(clk), .rst(rst),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data), .in_last(t_in_last),
    .img_flat(t_img_flat),
    .cnn_rst(t_cnn_rst), .cnn_enable(t_cnn_enable), .cnn_done(t_cnn_done), .cnn_value(t_cnn_value),
    .res_valid(t_res_valid), .res_ready(t_res_ready), .res_data(t_res_data),
    .err_len(t_err_len), .err_timeout(t_err_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Core model: done pulses core_lat cycles after the enable cycle.
  int            core_lat = 40;
  logic [DW-1:0] core_val = '0;
  logic          stray_req = 1'b0;
  logic [DW-1:0] stray_val = '0;
  int            core_cnt = 0;

  initial begin
    cnn_done  = 1'b0;
    cnn_value = '0;
    forever begin
      @(posedge clk); #2;
      cnn_done = 1'b0;
      if (rst) core_cnt = 0;
      else if (cnn_enable) core_cnt = core_lat;
      else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          cnn_done  = 1'b1;
          cnn_value = core_val;
        end
      end
      if (stray_req) begin
        cnn_done  = 1'b1;
        cnn_value = stray_val;
      end
    end
  end

  // Monitor: event counters, cycle stamps and cycle-by-cycle invariants.
  int cyc = 0, n_crst = 0, n_en = 0, n_elen = 0, n_eto = 0, n_res = 0, viol = 0;
  int t_crst = -10, t_en = -10, t_elen = -10, t_last = -10, t_rv = -10;
  logic [DW-1:0]      last_res = '0;
  logic [NPIX*DW-1:0] prev_img = '0;
  logic [DW-1:0]      prev_rd = '0;
  logic prev_acc = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0, prev_rst = 1'b1;

  initial begin
    forever begin
      @(posedge clk); #3;
      cyc++;
      if (cnn_rst) begin n_crst++; t_crst = cyc; end
      if (cnn_enable) begin
        n_en++;
        if (t_crst != cyc - 1) viol++;
        t_en = cyc;
      end
      if (err_len) begin n_elen++; t_elen = cyc; end
      if (err_timeout) n_eto++;
      if (res_valid && !prev_rv) t_rv = cyc;
      if (res_valid && res_ready) begin n_res++; last_res = res_data; end
      if (in_valid && in_ready && in_last) t_last = cyc;
      if (!rst && !prev_rst) begin
        if (img_flat != prev_img && !prev_acc) viol++;
        if (prev_rv && !prev_rr && (!res_valid || res_data != prev_rd)) viol++;
      end
      prev_img = img_flat;
      prev_acc = in_valid & in_ready;
      prev_rv  = res_valid;
      prev_rr  = res_ready;
      prev_rd  = res_data;
      prev_rst = rst;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic check(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Frame-level model of the image buffer contents.
  logic [DW-1:0] model_img [NPIX];

  task automatic check_img(input string nm);
    int bad = 0;
    for (int i = 0; i < NPIX; i++)
      if (img_flat[i*DW +: DW] !== model_img[i]) bad++;
    check(nm, bad, 0);
  endtask

  // Send n beats (in_last on the final one), optionally with idle gaps.
  task automatic send_frame(input int n, input int gap_pct, input bit seq);
    int   k = 0;
    int   budget = 0;
    logic rdy;
    while (k < n) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        tick();
      end else begin
        in_valid = 1'b1;
        in_data  = seq ? DW'(k) : DW'($urandom);
        in_last  = (k == n - 1);
        rdy = in_ready;
        tick();
        if (rdy) begin
          if (k < NPIX) model_img[k] = in_data;
          k++;
        end
      end
      budget++;
      if (budget > 3000) begin
        check("send_budget_beats", k, n);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Let the loader return to accepting input, with a random consumer.
  task automatic wait_idle(input int rr_pct);
    int c = 0;
    do begin
      res_ready = ($urandom_range(99) < rr_pct);
      tick();
      c++;
    end while ((!in_ready || c < 3) && c < 5000);
    res_ready = 1'b1;
    check("idle_within_budget", c < 5000, 1);
  endtask

  task automatic run_frame(input int n, input int lat, input logic [DW-1:0] val, input int rr,
                           input bit exp_err, input bit exp_launch, input int gaps);
    int e0 = n_elen, l0 = n_en, r0 = n_res, c0 = n_crst;
    core_lat = lat;
    core_val = val;
    send_frame(n, gaps, 1'b0);
    wait_idle(rr);
    check("err_len_pulses", n_elen - e0, exp_err);
    check("launches", n_en - l0, exp_launch);
    check("core_resets", n_crst - c0, exp_launch);
    check("results", n_res - r0, exp_launch);
    if (exp_launch) begin
      check("res_data", last_res, val);
      check("cnn_rst_after_last", t_crst, t_last + 1);
      check("res_latency", t_rv - t_en, lat + 1);
    end
    if (exp_err && gaps == 0)
      check("err_len_time", t_elen, (n < NPIX) ? t_last + 1 : t_last - (n - NPIX) + 1);
    check_img("img_words_bad");
    $display("frame beats=%0d lat=%0d gaps=%0d: err_len=%0d launched=%0d result=0x%0h",
             n, lat, gaps, n_elen - e0, n_en - l0, last_res);
  endtask

  task automatic run_to_frame(output int fcr, output int fen, output int fto, output int nto,
                              output int rvs, output int frdy, output int bad);
    fcr = -1; fen = -1; fto = -1; frdy = -1; nto = 0; rvs = 0; bad = 0;
    for (int k = 0; k < NPIX; k++) begin
      t_in_valid = 1'b1;
      t_in_data  = DW'(k);
      t_in_last  = (k == NPIX - 1);
      if (!t_in_ready) bad++;
      tick();
    end
    t_in_valid = 1'b0;
    t_in_last  = 1'b0;
    for (int c = NPIX; c < NPIX + 30; c++) begin
      if (t_cnn_rst && fcr < 0) fcr = c;
      if (t_cnn_enable && fen < 0) fen = c;
      if (t_err_timeout) begin nto++; if (fto < 0) fto = c; end
      if (t_res_valid) rvs++;
      if (t_in_ready && frdy < 0) frdy = c;
      tick();
    end
    for (int i = 0; i < NPIX; i++)
      if (t_img_flat[i*DW +: DW] !== DW'(i)) bad++;
  endtask

  typedef struct {
    int            n;
    int            lat;
    logic [DW-1:0] val;
    int            rr_pct;
    bit            exp_err;
    bit            exp_launch;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int fcr, fen, frv, frdy, ncr, bad, fto, nto, rvs;
    logic [DW-1:0] rvd;
    int e0, t0, r0;

    tbl[0] = '{64, 40, 32'h0000_1234, 100, 1'b0, 1'b1};
    tbl[1] = '{10, 10, 32'h0000_A5A5, 100, 1'b1, 1'b0};
    tbl[2] = '{64, 12, 32'h0BAD_F00D, 100, 1'b0, 1'b1};
    tbl[3] = '{70, 10, 32'h1111_2222, 100, 1'b1, 1'b0};
    tbl[4] = '{64,  5, 32'h3333_4444,  50, 1'b0, 1'b1};
    tbl[5] = '{ 1,  5, 32'h5555_6666, 100, 1'b1, 1'b0};
    tbl[6] = '{64,  1, 32'hFFFF_FFFF, 100, 1'b0, 1'b1};

    for (int i = 0; i < NPIX; i++) model_img[i] = '0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; res_ready = 1'b1;
    t_in_valid = 1'b0; t_in_last = 1'b0; t_in_data = '0;

    // Reset state.
    tick(); tick(); tick();
    check("in_ready_during_rst", in_ready, 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_cnn_rst", cnn_rst, 0);
    check("rst_cnn_enable", cnn_enable, 0);
    check("rst_err_len", err_len, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_img_zero", img_flat == '0, 1);
    check("rst_to_in_ready", t_in_ready, 1);

    // Nominal frame, cycle-exact: last beat at 63, cnn_rst 64, enable 65, result 106.
    core_lat = 40; core_val = 32'h1234; res_ready = 1'b1;
    send_frame(NPIX, 0, 1'b1);
    fcr = -1; fen = -1; frv = -1; frdy = -1; ncr = 0; rvd = '0;
    for (int c = NPIX; c < NPIX + 50; c++) begin
      if (cnn_rst) begin ncr++; if (fcr < 0) fcr = c; end
      if (cnn_enable && fen < 0) fen = c;
      if (res_valid && frv < 0) begin frv = c; rvd = res_data; end
      if (in_ready && frdy < 0) frdy = c;
      tick();
    end
    check("nom_cnn_rst_cycle", fcr, 64);
    check("nom_cnn_rst_count", ncr, 1);
    check("nom_enable_cycle", fen, 65);
    check("nom_res_valid_cycle", frv, 65 + 41);
    check("nom_res_data", rvd, 32'h1234);
    check("nom_in_ready_return", frdy, 65 + 42);
    for (int i = 0; i < NPIX; i++) model_img[i] = DW'(i);
    check_img("nom_img_words_bad");
    $display("frame nominal: cnn_rst@%0d enable@%0d res_valid@%0d data=0x%0h", fcr, fen, frv, rvd);

    // Backpressure: result held for 10 cycles with res_ready low.
    core_lat = 20; core_val = 32'hCAFE_0042; res_ready = 1'b0;
    r0 = n_res;
    send_frame(NPIX, 0, 1'b0);
    begin
      int c = 0;
      while (!res_valid && c < 200) begin tick(); c++; end
      check("bp_res_valid_seen", res_valid, 1);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!res_valid || res_data !== 32'hCAFE_0042 || in_ready) bad++;
      tick();
    end
    check("bp_hold_bad_cycles", bad, 0);
    res_ready = 1'b1;
    tick();
    check("bp_in_ready_after_release", in_ready, 1);
    check("bp_res_valid_dropped", res_valid, 0);
    check("bp_results", n_res - r0, 1);
    check("bp_res_data", last_res, 32'hCAFE_0042);
    check_img("bp_img_words_bad");
    $display("frame backpressure: result=0x%0h", last_res);

    // Table-driven frames: nominal, short, long, single-beat, slow consumer.
    for (int i = 0; i < 7; i++)
      run_frame(tbl[i].n, tbl[i].lat, tbl[i].val, tbl[i].rr_pct,
                tbl[i].exp_err, tbl[i].exp_launch, 0);

    // Reset in the middle of WAIT, then a stray done while filling.
    core_lat = 500; core_val = 32'h7777_7777;
    send_frame(NPIX, 0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("rw_in_wait_not_ready", in_ready, 0);
    e0 = n_elen; t0 = n_eto; r0 = n_res;
    rst = 1'b1;
    tick();
    check("rw_ready_low_in_rst", in_ready, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < NPIX; i++) model_img[i] = '0;
    check("rw_in_ready", in_ready, 1);
    check("rw_res_valid", res_valid, 0);
    check("rw_res_data", res_data, 0);
    check("rw_cnn_rst", cnn_rst, 0);
    check("rw_cnn_enable", cnn_enable, 0);
    check("rw_img_zero", img_flat == '0, 1);
    stray_val = 32'hDEAD_BEEF;
    stray_req = 1'b1;
    tick();
    stray_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("stray_no_res_valid", res_valid, 0);
    check("stray_res_data", res_data, 0);
    check("stray_in_ready", in_ready, 1);
    check("rw_no_err_len", n_elen - e0, 0);
    check("rw_no_err_timeout", n_eto - t0, 0);
    check("rw_no_result", n_res - r0, 0);
    $display("frame reset-mid-wait: aborted, stray done ignored");
    run_frame(NPIX, 7, 32'h0101_0202, 100, 1'b0, 1'b1, 0);

    // Randomized frames against the frame-level model.
    for (int f = 0; f < 25; f++) begin
      int r = $urandom_range(9);
      int n;
      if (r < 6) n = NPIX;
      else if (r < 8) n = $urandom_range(NPIX - 1, 1);
      else n = $urandom_range(NPIX + 10, NPIX + 1);
      run_frame(n, $urandom_range(60, 1), DW'($urandom), $urandom_range(100, 20),
                n != NPIX, n == NPIX, $urandom_range(30));
    end

    // Watchdog: core never finishes; WAIT entered at 66, err_timeout 16 cycles later.
    run_to_frame(fcr, fen, fto, nto, rvs, frdy, bad);
    check("to_cnn_rst_cycle", fcr, NPIX);
    check("to_enable_cycle", fen, NPIX + 1);
    check("to_err_timeout_cycle", fto, NPIX + 2 + TO_T);
    check("to_err_timeout_count", nto, 1);
    check("to_no_res_valid", rvs, 0);
    check("to_in_ready_return", frdy, NPIX + 2 + TO_T);
    check("to_beats_and_img_bad", bad, 0);
    $display("frame timeout: err_timeout@%0d in_ready@%0d", fto, frdy);
    run_to_frame(fcr, fen, fto, nto, rvs, frdy, bad);
    check("to2_cnn_rst_cycle", fcr, NPIX);
    check("to2_enable_cycle", fen, NPIX + 1);
    check("to2_err_timeout_count", nto, 1);
    check("to2_beats_and_img_bad", bad, 0);
    $display("frame timeout-2: cnn_rst@%0d enable@%0d", fcr, fen);

    check("invariant_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnn_frame_loader.md
# cnn_frame_loader

Upstream front end of the CNN core. It accepts an 8x8 image as a 64-beat valid/ready pixel stream and buffers it into a flat image register that drives the core's `input_img`. It then resets and launches the core, waits for its `done` pulse, and returns the scalar result on a valid/ready output port. It serialises frames, enforces frame length, and recovers from a hung core.

## Interface
- `NPIX`, 64: pixels per frame. The core's fixed 8x8 input.
- `DW`, 32: pixel and result width.
- `TIMEOUT`, 4096: maximum cycles spent in WAIT before the frame is abandoned.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: pixel beat valid.
- `in_ready`  out  1: loader accepts a beat.
- `in_data`  in  DW: pixel, row-major; beat k goes to buffer word k.
- `in_last`  in  1: marks final beat of a frame.
- `img_flat`  out  NPIX*DW: buffer; word i at bits [i*DW +: DW].
- `cnn_rst`  out  1: one-cycle reset pulse to the core.
- `cnn_enable`  out  1: one-cycle start pulse to the core.
- `cnn_done`  in  1: core completion pulse.
- `cnn_value`  in  DW: core result, valid in the `cnn_done` cycle.
- `res_valid`  out  1: result available.
- `res_ready`  in  1: consumer accepts the result.
- `res_data`  out  DW: captured result.
- `err_len`  out  1: one-cycle pulse on a frame-length violation.
- `err_timeout`  out  1: one-cycle pulse when the core fails to finish.

## Operation
States and transitions:
- FILL
  - `in_ready`=1. A beat is accepted when `in_valid & in_ready`.
  - Each accepted beat writes `buf[wr_ptr]` and increments `wr_ptr` (6 bits).
  - Beat with `in_last`=1 and `wr_ptr`==NPIX-1: accept, go to CLEAR, `wr_ptr` returns to 0.
  - Beat with `in_last`=1 and `wr_ptr`<NPIX-1: short frame. Pulse `err_len`, reset `wr_ptr` to 0, stay in FILL. Written words are not cleared.
  - Beat with `in_last`=0 and `wr_ptr`==NPIX-1: long frame. Pulse `err_len`, go to DRAIN.
- DRAIN
  - `in_ready`=1. Beats are discarded.
  - Accepted beat with `in_last`=1 goes to FILL with `wr_ptr`=0.
- CLEAR
  - `cnn_rst`=1 for exactly one cycle, then go to LAUNCH.
- LAUNCH
  - `cnn_enable`=1 for exactly one cycle.
  - Clear the watchdog counter, then go to WAIT.
- WAIT
  - `in_ready`=0. `img_flat` is held constant.
  - `cnn_done`=1: capture `cnn_value` into `res_data`, go to RESULT.
  - Otherwise increment the watchdog. When it reaches TIMEOUT-1, pulse `err_timeout` and go to FILL with no result. The next frame's CLEAR resets the core.
- RESULT
  - `res_valid`=1 and `res_data` are stable until `res_ready`=1.
  - On that handshake, go to FILL.

Rules:
- `in_ready` is high only in FILL and DRAIN. It is combinational from the state register and forced low while `rst`=1.
- `cnn_done` outside WAIT is ignored.
- `img_flat` changes only on accepted FILL beats.

## Timing
Reset: the cycle `rst` is sampled high sets:
- state=FILL, `wr_ptr`=0, buffer=0, watchdog=0
- `res_data`=0, `res_valid`=0
- `cnn_rst`=0, `cnn_enable`=0, `err_len`=0, `err_timeout`=0

Reset mid-operation in any state aborts immediately: no result, no error pulse.

Latencies:
- Back-to-back frame: 64 accept cycles, with the last beat at cycle 63.
- `cnn_rst` is high in cycle 64 and `cnn_enable` in cycle 65.
- WAIT is entered at cycle 66.
- `res_valid` rises the cycle after `cnn_done` is sampled.
- If `res_ready` is already high, RESULT lasts one cycle and `in_ready` returns high the following cycle.
- Minimum turnaround from last input beat to next accept = 3 + core latency + 1 cycles.

Error pulses:
- `err_len` is asserted in the cycle after the offending beat's accept edge.
- `err_timeout` is asserted in the cycle WAIT exits.

Output timing: all outputs except `in_ready` are registered.

## Test plan
- **Nominal frame:** pixels k=0..63 with `in_data`=k and `in_last` on beat 63; core model pulses `cnn_done` 40 cycles after `cnn_enable` with `cnn_value`=0x1234.
  - `img_flat` word i = i.
  - `cnn_rst` pulses at cycle 64, `cnn_enable` at cycle 65.
  - `res_valid` high with `res_data`=0x1234, 41 cycles after `cnn_enable`.
- **Backpressure:** hold `res_ready`=0 for 10 cycles.
  - `res_valid` and `res_data` stay stable and `in_ready` stays 0.
  - Releasing `res_ready` gives `in_ready`=1 on the next cycle.
- **Short frame:** `in_last` on beat 9.
  - Single `err_len` pulse, no `cnn_enable`.
  - A following clean 64-beat frame launches normally with `wr_ptr` starting at 0.
- **Long frame:** 70 beats with `in_last` on beat 69.
  - `err_len` pulses after beat 63, beats 64..69 are drained, no launch.
  - The next frame is processed correctly.
- **Timeout:** with TIMEOUT=16, the core never asserts `cnn_done`.
  - `err_timeout` pulses 16 cycles after entering WAIT, `res_valid` stays 0, `in_ready` returns to 1.
  - The next frame produces `cnn_rst` before `cnn_enable`.
- **Reset mid-WAIT**, plus a stray `cnn_done` during FILL.
  - All outputs return to reset values and `in_ready`=1 after `rst` drops.
  - The stray `done` produces no result.
